// File: rtl/lm75a_poll_ctrl.sv
// LM75A temperature poller: sequences START/WR/WR/START/WR/RD/RD/STOP through a byte I2C master; holds last good reading.
// Latency 25 clk IDLE->temp_valid with a zero-wait master; each command holds cmd_valid until cmd_ready, one outstanding.
module lm75a_poll_ctrl #(
  parameter logic [6:0] DEV_ADDR       = 7'h48,
  parameter int         POLL_CYCLES    = 5_000_000,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        poll_now,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  output logic        cmd_last,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  input  logic        rsp_nack,
  output logic        bus_abort,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        busy,
  output logic        err
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [3:0] {IDLE, S1, WA, WP, S2, RA, RM, RL, SP} state_t;

  state_t          state_q, state_d;
  logic            wait_q, wait_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic [PW-1:0]   pcnt_q;
  logic            pending_q;
  logic            nacked_q, nacked_d;
  logic [7:0]      msb_q, lsb_q;
  logic            tick, tmo, leave_idle, set_err, done_ok;

  assign tick = enable && (pcnt_q == POLL_LAST);
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (!enable || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    wcnt_d     = wcnt_q + TW'(1);
    nacked_d   = nacked_q;
    cmd_valid  = 1'b0;
    cmd_op     = OP_START;
    cmd_wdata  = 8'h00;
    cmd_last   = 1'b0;
    bus_abort  = 1'b0;
    tmo        = 1'b0;
    leave_idle = 1'b0;
    set_err    = 1'b0;
    done_ok    = 1'b0;

    if (state_q == IDLE) begin
      wcnt_d = '0;
      if (pending_q) begin
        state_d    = S1;
        wait_d     = 1'b0;
        nacked_d   = 1'b0;
        leave_idle = 1'b1;
      end
    end else begin
      // A response landing on the last allowed cycle still counts as in time.
      tmo = (wcnt_q == TMO_LAST) && !(wait_q && rsp_valid);
      if (tmo) begin
        bus_abort = 1'b1;
        set_err   = 1'b1;
        state_d   = IDLE;
        wait_d    = 1'b0;
        wcnt_d    = '0;
      end else if (!wait_q) begin
        cmd_valid = 1'b1;
        case (state_q)
          WA:      begin cmd_op = OP_WRITE; cmd_wdata = {DEV_ADDR, 1'b0}; end
          WP:      begin cmd_op = OP_WRITE; cmd_wdata = 8'h00; end
          RA:      begin cmd_op = OP_WRITE; cmd_wdata = {DEV_ADDR, 1'b1}; end
          RM:      cmd_op = OP_READ;
          RL:      begin cmd_op = OP_READ; cmd_last = 1'b1; end
          SP:      cmd_op = OP_STOP;
          default: cmd_op = OP_START;
        endcase
        if (cmd_ready) begin
          wait_d = 1'b1;
          wcnt_d = '0;
        end
      end else if (rsp_valid) begin
        wait_d = 1'b0;
        wcnt_d = '0;
        case (state_q)
          S1: state_d = WA;
          WA: state_d = rsp_nack ? SP : WP;
          WP: state_d = rsp_nack ? SP : S2;
          S2: state_d = RA;
          RA: state_d = rsp_nack ? SP : RM;
          RM: state_d = RL;
          RL: state_d = SP;
          default: begin
            state_d = IDLE;
            done_ok = !nacked_q;
          end
        endcase
        if (rsp_nack && (state_q == WA || state_q == WP || state_q == RA)) begin
          nacked_d = 1'b1;
          set_err  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= 1'b0;
      wcnt_q     <= '0;
      pending_q  <= 1'b0;
      nacked_q   <= 1'b0;
      msb_q      <= 8'h00;
      lsb_q      <= 8'h00;
      temp_data  <= 16'h0000;
      temp_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      wcnt_q    <= wcnt_d;
      nacked_q  <= nacked_d;
      // New requests win over the clear so a request seen while leaving IDLE is not lost.
      pending_q <= (pending_q && !leave_idle) || tick || poll_now;
      if (wait_q && rsp_valid && state_q == RM) msb_q <= rsp_rdata;
      if (wait_q && rsp_valid && state_q == RL) lsb_q <= rsp_rdata;
      temp_valid <= done_ok;
      if (done_ok) temp_data <= {msb_q, lsb_q};
      if (set_err) begin
        err <= 1'b1;
      end else if (done_ok) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lm75a_poll_ctrl.sv
// Bench for lm75a_poll_ctrl: behavioural I2C master plus table, hand-written and randomized transaction checks.
module tb_lm75a_poll_ctrl;
  localparam logic [6:0] ADDR = 7'h48;
  localparam int POLL = 50;
  localparam int TMO  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        poll_now = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_wdata;
  logic        cmd_last;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_rdata = 8'h00;
  logic        rsp_nack = 1'b0;
  logic        bus_abort;
  logic [15:0] temp_data;
  logic        temp_valid;
  logic        busy;
  logic        err;

  lm75a_poll_ctrl #(.DEV_ADDR(ADDR), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .poll_now(poll_now),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .cmd_last(cmd_last), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .bus_abort(bus_abort), .temp_data(temp_data), .temp_valid(temp_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] op;
    logic [7:0] wdata;
    logic       last;
    int         cyc;
    int         vcyc;
  } cmd_rec_t;

  typedef struct {
    int          nack;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    int          ncmds;
    logic [15:0] temp;
    logic        err_e;
    int          ntv;
  } vec_t;

  cmd_rec_t    cmd_log[$];
  int          tv_cyc[$];
  logic [15:0] tv_dat[$];
  int          ab_cyc[$];
  cmd_rec_t    canon[8];

  int checks = 0;
  int errors = 0;

  // Master behaviour knobs (written by the test process only).
  int         ready_hold = 0;
  int         rsp_lat = 2;
  int         nack_idx = 0;
  int         drop_idx = 0;
  logic [7:0] msb_v = 8'h00;
  logic [7:0] lsb_v = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_rec_t mk(input logic [1:0] op, input logic [7:0] wd, input logic last);
    cmd_rec_t r;
    r.op = op; r.wdata = wd; r.last = last; r.cyc = 0; r.vcyc = 0;
    return r;
  endfunction

  // Behavioural byte-level I2C master: inputs set on negedge, outputs sampled 1 time unit later.
  initial begin
    cmd_rec_t   rec;
    bit         outstanding;
    bit         prev_held;
    int         hold_cnt, cmd_idx, out_idx, rsp_due, vcyc;
    logic [1:0] out_op;
    logic       out_last;
    logic [10:0] held_f;
    outstanding = 0; prev_held = 0; hold_cnt = 0; cmd_idx = 0; out_idx = 0;
    rsp_due = 0; vcyc = 0; out_op = 2'd0; out_last = 1'b0; held_f = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0; prev_held = 0; hold_cnt = 0; cmd_idx = 0; vcyc = 0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
      end else begin
        cmd_ready = (hold_cnt >= ready_hold);
        rsp_valid = outstanding && (cyc == rsp_due) && (out_idx != drop_idx);
        rsp_nack  = rsp_valid && (out_op == 2'd1) && (out_idx == nack_idx);
        rsp_rdata = (rsp_valid && out_op == 2'd2) ? (out_last ? lsb_v : msb_v) : 8'h00;
        #1;
        if (rsp_valid) outstanding = 0;
        if (cmd_valid) begin
          vcyc++;
          chk("single_outstanding", 32'(outstanding), 0);
          if (prev_held) chk("cmd_stable", 32'({cmd_op, cmd_wdata, cmd_last}), 32'(held_f));
          if (cmd_ready) begin
            rec.op = cmd_op; rec.wdata = cmd_wdata; rec.last = cmd_last; rec.cyc = cyc; rec.vcyc = vcyc;
            cmd_log.push_back(rec);
            outstanding = 1; out_op = cmd_op; out_last = cmd_last;
            cmd_idx++; out_idx = cmd_idx; rsp_due = cyc + rsp_lat;
            hold_cnt = 0; prev_held = 0; vcyc = 0;
          end else begin
            hold_cnt++; prev_held = 1; held_f = {cmd_op, cmd_wdata, cmd_last};
          end
        end else begin
          prev_held = 0;
        end
        if (temp_valid) begin
          tv_cyc.push_back(cyc);
          tv_dat.push_back(temp_data);
        end
        if (bus_abort) begin
          ab_cyc.push_back(cyc);
          outstanding = 0;
        end
        if (!busy) cmd_idx = 0;
      end
    end
  end

  task automatic run_poll(input int budget, output int p);
    int n;
    n = 0;
    @(negedge clk);
    poll_now = 1'b1;
    p = cyc;
    @(negedge clk);
    poll_now = 1'b0;
    while (!busy && n < budget) begin @(negedge clk); n++; end
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("poll_completes_in_budget", 32'(n < budget), 1);
    #2;
  endtask

  // Expected command stream: canonical sequence, cut after a NACKed write and closed with STOP.
  task automatic check_cmds(input string tag, input int base, input int k, input int n);
    cmd_rec_t e;
    chk({tag, "_ncmds"}, 32'(cmd_log.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < cmd_log.size(); i++) begin
      e = (k != 0 && i == k) ? canon[7] : canon[i];
      chk($sformatf("%s_cmd%0d", tag, i),
          32'({cmd_log[base+i].op, cmd_log[base+i].wdata, cmd_log[base+i].last}),
          32'({e.op, e.wdata, e.last}));
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    vec_t        vecs[6];
    int          p, bc, bt, ba, e, k, h, l;
    int          opts[6];
    logic [15:0] model_temp;
    logic        model_err;
    int          exp_tv[5];

    canon[0] = mk(2'd0, 8'h00, 1'b0);
    canon[1] = mk(2'd1, {ADDR, 1'b0}, 1'b0);
    canon[2] = mk(2'd1, 8'h00, 1'b0);
    canon[3] = mk(2'd0, 8'h00, 1'b0);
    canon[4] = mk(2'd1, {ADDR, 1'b1}, 1'b0);
    canon[5] = mk(2'd2, 8'h00, 1'b0);
    canon[6] = mk(2'd2, 8'h00, 1'b1);
    canon[7] = mk(2'd3, 8'h00, 1'b0);

    vecs[0] = '{0, 8'h19, 8'h80, 8, 16'h1980, 1'b0, 1};
    vecs[1] = '{2, 8'h55, 8'h55, 3, 16'h1980, 1'b1, 0};
    vecs[2] = '{0, 8'h7F, 8'h80, 8, 16'h7F80, 1'b0, 1};
    vecs[3] = '{3, 8'h11, 8'h22, 4, 16'h7F80, 1'b1, 0};
    vecs[4] = '{5, 8'h33, 8'h44, 6, 16'h7F80, 1'b1, 0};
    vecs[5] = '{0, 8'hE7, 8'h00, 8, 16'hE700, 1'b0, 1};

    #23;
    chk("reset_outputs", 32'({cmd_valid, cmd_op, cmd_wdata, cmd_last, bus_abort, temp_valid, busy, err}), 0);
    chk("reset_temp", 32'(temp_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_request", 32'({busy, cmd_valid}), 0);

    // Table: clean reads and NACKs at each write position.
    for (int r = 0; r < 6; r++) begin
      nack_idx = vecs[r].nack; msb_v = vecs[r].msb; lsb_v = vecs[r].lsb;
      bc = cmd_log.size(); bt = tv_cyc.size();
      run_poll(400, p);
      chk($sformatf("row%0d_ncmds", r), 32'(cmd_log.size() - bc), 32'(vecs[r].ncmds));
      check_cmds($sformatf("row%0d", r), bc, vecs[r].nack, vecs[r].ncmds);
      chk($sformatf("row%0d_temp", r), 32'(temp_data), 32'(vecs[r].temp));
      chk($sformatf("row%0d_err", r), 32'(err), 32'(vecs[r].err_e));
      chk($sformatf("row%0d_ntv", r), 32'(tv_cyc.size() - bt), 32'(vecs[r].ntv));
      chk($sformatf("row%0d_busy", r), 32'(busy), 0);
      if (r == 0 && tv_cyc.size() > bt && cmd_log.size() > bc) begin
        chk("first_cmd_cycle", 32'(cmd_log[bc].cyc - p), 2);
        chk("temp_valid_latency", 32'(tv_cyc[bt] - p), 26);
        chk("temp_valid_data", 32'(tv_dat[bt]), 32'h1980);
      end
    end
    nack_idx = 0;

    // Backpressure: ready held low 10 cycles per command.
    ready_hold = 10; msb_v = 8'hA5; lsb_v = 8'h5A;
    bc = cmd_log.size();
    run_poll(600, p);
    check_cmds("hold", bc, 0, 8);
    for (int i = 0; i < 8 && bc + i < cmd_log.size(); i++)
      chk($sformatf("hold_valid_cycles%0d", i), 32'(cmd_log[bc+i].vcyc), 11);
    chk("hold_temp", 32'(temp_data), 32'hA55A);
    ready_hold = 0;

    // Timeout: no response to the first READ.
    drop_idx = 6;
    bc = cmd_log.size(); bt = tv_cyc.size(); ba = ab_cyc.size();
    run_poll(400, p);
    check_cmds("tmo", bc, 0, 6);
    chk("tmo_abort_count", 32'(ab_cyc.size() - ba), 1);
    if (ab_cyc.size() > ba && cmd_log.size() >= bc + 6)
      chk("tmo_abort_delay", 32'(ab_cyc[ba] - cmd_log[bc+5].cyc), 32'(TMO));
    chk("tmo_err", 32'(err), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_ntv", 32'(tv_cyc.size() - bt), 0);
    chk("tmo_temp", 32'(temp_data), 32'hA55A);
    drop_idx = 0;

    // Periodic polling with one extra poll_now during a transaction.
    msb_v = 8'h0C; lsb_v = 8'h40;
    bt = tv_cyc.size();
    @(negedge clk);
    enable = 1'b1;
    e = cyc;
    wait_until(e + 105);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_until(e + 232);
    #2;
    exp_tv = '{e + 75, e + 125, e + 150, e + 175, e + 225};
    chk("period_ntv", 32'(tv_cyc.size() - bt), 5);
    for (int i = 0; i < 5 && bt + i < tv_cyc.size(); i++) begin
      chk($sformatf("period_tv_cycle%0d", i), 32'(tv_cyc[bt+i]), 32'(exp_tv[i]));
      chk($sformatf("period_tv_data%0d", i), 32'(tv_dat[bt+i]), 32'h0C40);
    end
    chk("period_err_cleared", 32'(err), 0);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    chk("disabled_idle", 32'(busy), 0);

    // Asynchronous reset during the final READ.
    msb_v = 8'h12; lsb_v = 8'h34;
    @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    k = 0;
    while (!(cmd_valid && cmd_op == 2'd2 && cmd_last) && k < 100) begin @(negedge clk); k++; end
    chk("rl_reached", 32'(k < 100), 1);
    chk("pre_reset_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({cmd_valid, cmd_op, cmd_wdata, cmd_last, bus_abort, temp_valid, busy, err}), 0);
    chk("async_reset_temp", 32'(temp_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bc = cmd_log.size();
    repeat (60) @(negedge clk);
    chk("post_reset_no_cmds", 32'(cmd_log.size() - bc), 0);
    chk("post_reset_busy", 32'(busy), 0);
    run_poll(400, p);
    chk("post_reset_temp", 32'(temp_data), 32'h1234);

    // Randomized transactions against the model.
    opts = '{0, 0, 0, 2, 3, 5};
    model_temp = 16'h1234;
    model_err = 1'b0;
    for (int it = 0; it < 16; it++) begin
      k = opts[$urandom_range(0, 5)];
      h = $urandom_range(0, 3);
      l = $urandom_range(2, 5);
      nack_idx = k; ready_hold = h; rsp_lat = l;
      msb_v = 8'($urandom); lsb_v = 8'($urandom);
      bc = cmd_log.size(); bt = tv_cyc.size();
      run_poll(600, p);
      if (k == 0) model_temp = {msb_v, lsb_v};
      model_err = (k != 0);
      check_cmds($sformatf("rnd%0d", it), bc, k, (k == 0) ? 8 : k + 1);
      chk($sformatf("rnd%0d_temp", it), 32'(temp_data), 32'(model_temp));
      chk($sformatf("rnd%0d_err", it), 32'(err), 32'(model_err));
      chk($sformatf("rnd%0d_ntv", it), 32'(tv_cyc.size() - bt), (k == 0) ? 1 : 0);
      if (k == 0 && tv_cyc.size() > bt)
        chk($sformatf("rnd%0d_latency", it), 32'(tv_cyc[bt] - p), 32'(2 + 8 * (h + l + 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
